// File: rtl/b01_pkg.sv
// Shared definitions for the b01 line feeder: FSM state encoding and the
// default word width / inter-word gap used by the feeder and its neighbours.
package b01_pkg;

    // Default serialized word width in bits.
    localparam int WIDTH_DEFAULT = 8;

    // Default number of idle cycles inserted after each word.
    localparam int GAP_DEFAULT = 1;

    // Feeder FSM: waiting for a word, shifting data bits, driving the gap.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } b01_state_e;

endpackage

// File: rtl/b01_dual_shreg.sv
// Pair of WIDTH-bit right-shifting registers sharing load and shift enables.
// The LSB of each register is presented as the next serial bit to emit.
module b01_dual_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_a,
    input  logic [WIDTH-1:0] load_b,
    output logic             lsb_a,
    output logic             lsb_b
);

    logic [WIDTH-1:0] reg_a_r;
    logic [WIDTH-1:0] reg_b_r;

    // Load wins over shift; shifting brings zeros in at the top.
    always_ff @(posedge clock) begin
        if (reset) begin
            reg_a_r <= '0;
            reg_b_r <= '0;
        end else if (load) begin
            reg_a_r <= load_a;
            reg_b_r <= load_b;
        end else if (shift) begin
            reg_a_r <= {1'b0, reg_a_r[WIDTH-1:1]};
            reg_b_r <= {1'b0, reg_b_r[WIDTH-1:1]};
        end
    end

    assign lsb_a = reg_a_r[0];
    assign lsb_b = reg_b_r[0];

endmodule

// File: rtl/b01_line_feeder.sv
// Serializes word pairs LSB-first onto two registered lines (line1/line2)
// that drive a downstream b01 comparator. Each word is followed by GAP idle
// cycles; with GAP=0 back-to-back words stream without any bubble.
module b01_line_feeder
    import b01_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int GAP   = GAP_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] word_a,
    input  logic [WIDTH-1:0] word_b,
    output logic             line1,
    output logic             line2,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frames_sent
);

    localparam int              BCW         = $clog2(WIDTH + 1);
    localparam logic [BCW-1:0]  BIT_LAST    = BCW'(WIDTH - 1);
    localparam logic [BCW-1:0]  BIT_PRELAST = BCW'(WIDTH - 2);
    localparam logic [2:0]      GAP_LAST    = 3'(GAP - 1);
    localparam bit              HAS_GAP     = (GAP != 0);

    b01_state_e       state_r;
    b01_state_e       state_next_s;
    logic [BCW-1:0]   bit_cnt_r;
    logic [BCW-1:0]   bit_cnt_next_s;
    logic [2:0]       gap_cnt_r;
    logic [2:0]       gap_cnt_next_s;
    logic             line1_r;
    logic             line2_r;
    logic             line1_next_s;
    logic             line2_next_s;
    logic             busy_r;
    logic             frame_done_r;
    logic             frame_done_next_s;
    logic [15:0]      frames_sent_r;

    logic             last_bit_s;
    logic             last_gap_s;
    logic             in_ready_s;
    logic             transfer_s;
    logic             load_s;
    logic             shift_s;
    logic [WIDTH-1:0] load_a_s;
    logic [WIDTH-1:0] load_b_s;
    logic             shreg_lsb_a_s;
    logic             shreg_lsb_b_s;

    // Handshake: accept only when idle or on the final output cycle of a word.
    always_comb begin
        last_bit_s = (state_r == ST_SHIFT) && (bit_cnt_r == BIT_LAST);
        last_gap_s = (state_r == ST_GAP) && (gap_cnt_r == GAP_LAST);
        in_ready_s = 1'b0;
        if (reset) begin
            in_ready_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:  in_ready_s = 1'b1;
                ST_SHIFT: in_ready_s = (!HAS_GAP) && last_bit_s;
                ST_GAP:   in_ready_s = last_gap_s;
                default:  in_ready_s = 1'b0;
            endcase
        end
        transfer_s = in_valid && in_ready_s;
    end

    // FSM next state; a transfer on the final output cycle chains straight into SHIFT.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (transfer_s) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!last_bit_s) begin
                    state_next_s = ST_SHIFT;
                end else if (HAS_GAP) begin
                    state_next_s = ST_GAP;
                end else if (transfer_s) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (!last_gap_s) begin
                    state_next_s = ST_GAP;
                end else if (transfer_s) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath: bit 0 goes straight to the line flops at capture, the rest
    // of the word is parked pre-shifted so the shifter LSB is always the next bit.
    always_comb begin
        load_s   = transfer_s;
        shift_s  = (state_r == ST_SHIFT) && !transfer_s;
        load_a_s = {1'b0, word_a[WIDTH-1:1]};
        load_b_s = {1'b0, word_b[WIDTH-1:1]};

        line1_next_s = 1'b0;
        line2_next_s = 1'b0;
        if (transfer_s) begin
            line1_next_s = word_a[0];
            line2_next_s = word_b[0];
        end else if ((state_r == ST_SHIFT) && !last_bit_s) begin
            line1_next_s = shreg_lsb_a_s;
            line2_next_s = shreg_lsb_b_s;
        end else begin
            line1_next_s = 1'b0;
            line2_next_s = 1'b0;
        end
    end

    // Counters: bit index of the bit on the lines, gap cycle index, and
    // frame_done armed one cycle ahead so it lands with the MSB.
    always_comb begin
        bit_cnt_next_s = '0;
        if (transfer_s) begin
            bit_cnt_next_s = '0;
        end else if ((state_r == ST_SHIFT) && !last_bit_s) begin
            bit_cnt_next_s = bit_cnt_r + BCW'(1);
        end else begin
            bit_cnt_next_s = '0;
        end

        gap_cnt_next_s = 3'd0;
        if ((state_r == ST_GAP) && !last_gap_s) begin
            gap_cnt_next_s = gap_cnt_r + 3'd1;
        end else begin
            gap_cnt_next_s = 3'd0;
        end

        frame_done_next_s = (state_r == ST_SHIFT) && (bit_cnt_r == BIT_PRELAST);
    end

    // State, counters and all output registers; reset aborts any word in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            bit_cnt_r     <= '0;
            gap_cnt_r     <= 3'd0;
            line1_r       <= 1'b0;
            line2_r       <= 1'b0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            frames_sent_r <= 16'd0;
        end else begin
            state_r      <= state_next_s;
            bit_cnt_r    <= bit_cnt_next_s;
            gap_cnt_r    <= gap_cnt_next_s;
            line1_r      <= line1_next_s;
            line2_r      <= line2_next_s;
            busy_r       <= (state_next_s != ST_IDLE);
            frame_done_r <= frame_done_next_s;
            if (frame_done_r) begin
                frames_sent_r <= frames_sent_r + 16'd1;
            end
        end
    end

    b01_dual_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clock  (clock),
        .reset  (reset),
        .load   (load_s),
        .shift  (shift_s),
        .load_a (load_a_s),
        .load_b (load_b_s),
        .lsb_a  (shreg_lsb_a_s),
        .lsb_b  (shreg_lsb_b_s)
    );

    assign in_ready    = in_ready_s;
    assign line1       = line1_r;
    assign line2       = line2_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign frames_sent = frames_sent_r;

endmodule

// File: tb/tb_b01_line_feeder.sv
// Bench for b01_line_feeder: two instances (GAP=0 and GAP=1, WIDTH=8) share
// one input stream; each is compared every cycle to a queue-based timeline
// model, plus a vector table and directed multi-cycle sequences.
module tb_b01_line_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  word_a;
    logic [7:0]  word_b;
    logic [1:0]  rdy_o;
    logic [1:0]  l1_o;
    logic [1:0]  l2_o;
    logic [1:0]  busy_o;
    logic [1:0]  fd_o;
    logic [15:0] fr_o [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    b01_line_feeder #(.WIDTH(8), .GAP(0)) u_g0 (
        .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_o[0]),
        .word_a(word_a), .word_b(word_b), .line1(l1_o[0]), .line2(l2_o[0]),
        .busy(busy_o[0]), .frame_done(fd_o[0]), .frames_sent(fr_o[0]));

    b01_line_feeder #(.WIDTH(8), .GAP(1)) u_g1 (
        .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_o[1]),
        .word_a(word_a), .word_b(word_b), .line1(l1_o[1]), .line2(l2_o[1]),
        .busy(busy_o[1]), .frame_done(fd_o[1]), .frames_sent(fr_o[1]));

    // Model: each instance owns a timeline of future line samples. The head
    // is what is on the lines now; an accepted word appends 8 data samples
    // followed by its gap samples. Ready means at most the current sample is left.
    typedef struct packed {logic l1; logic l2; logic fd;} smp_t;
    smp_t        mq [2][$];
    logic [15:0] mcnt [2];

    function automatic int gap_of(int i);
        return (i == 0) ? 0 : 1;
    endfunction

    function automatic logic model_ready(int i);
        return !reset && (mq[i].size() <= 1);
    endfunction

    function automatic logic [31:0] e(logic l1, logic l2, logic fd, logic bz, logic rd, logic [15:0] f);
        return {11'd0, l1, l2, fd, bz, rd, f};
    endfunction

    function automatic logic [31:0] model_out(int i);
        smp_t s  = '0;
        logic bz = 1'b0;
        if (mq[i].size() > 0) begin
            s  = mq[i][0];
            bz = 1'b1;
        end
        return e(s.l1, s.l2, s.fd, bz, model_ready(i), mcnt[i]);
    endfunction

    function automatic logic [31:0] dut_out(int i);
        return e(l1_o[i], l2_o[i], fd_o[i], busy_o[i], rdy_o[i], fr_o[i]);
    endfunction

    function automatic void model_edge(int i, logic x, logic r, logic [7:0] a, logic [7:0] b);
        smp_t s;
        if (r) begin
            mq[i].delete();
            mcnt[i] = 16'd0;
        end else begin
            if (mq[i].size() > 0) begin
                s = mq[i].pop_front();
                if (s.fd) mcnt[i] = mcnt[i] + 16'd1;
            end
            if (x) begin
                for (int k = 0; k < 8; k++) mq[i].push_back({a[k], b[k], (k == 7)});
                for (int g = 0; g < gap_of(i); g++) mq[i].push_back(3'b000);
            end
        end
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // One clock cycle: drive at negedge, advance model at posedge, compare at next negedge.
    task automatic step(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b);
        logic [1:0] x;
        reset    = r;
        in_valid = v;
        word_a   = a;
        word_b   = b;
        for (int i = 0; i < 2; i++) x[i] = v && model_ready(i);
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i, x[i], r, a, b);
        @(negedge clk);
        check("model_g0", dut_out(0), model_out(0));
        check("model_g1", dut_out(1), model_out(1));
    endtask

    typedef struct {
        logic        r;
        logic        v;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int guard;
        int cyc;
        int busy_cnt;
        int last_busy;
        logic [31:0] fd_mask;
        int both_hi;

        reset    = 1'b1;
        in_valid = 1'b0;
        word_a   = 8'h00;
        word_b   = 8'h00;
        mcnt[0]  = 16'd0;
        mcnt[1]  = 16'd0;
        @(negedge clk);

        // Vector table for the GAP=1 instance: A5/0F frame, ignored inputs mid-word.
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 8'h00, e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0)};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 8'h00, e(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0)};
        tbl[2]  = '{1'b0, 1'b1, 8'hA5, 8'h0F, e(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0)};
        tbl[3]  = '{1'b0, 1'b0, 8'hFF, 8'hFF, e(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0)};
        tbl[4]  = '{1'b0, 1'b1, 8'h33, 8'h33, e(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0)};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 8'h00, e(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0)};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 8'h00, e(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0)};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 8'h00, e(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0)};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 8'h00, e(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0)};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 8'h00, e(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0)};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 8'h00, e(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1)};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 8'h00, e(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1)};
        for (int n = 0; n < 12; n++) begin
            step(tbl[n].r, tbl[n].v, tbl[n].a, tbl[n].b);
            check($sformatf("vec%0d", n), dut_out(1), tbl[n].exp);
        end

        // GAP=0 streaming: valid held through three accepted words.
        step(1'b1, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 8'h00, 8'h00);
        acc = 0; guard = 0; cyc = 0; busy_cnt = 0; last_busy = 0; fd_mask = 32'd0;
        while (acc < 3 && guard < 60) begin
            logic xr;
            xr = model_ready(0);
            step(1'b0, 1'b1, 8'h3C + 8'(acc), 8'hC3 - 8'(acc));
            if (xr) acc++;
            guard++;
            if (acc > 0) begin
                cyc++;
                if (busy_o[0]) begin busy_cnt++; last_busy = cyc; end
                if (fd_o[0]) fd_mask[cyc] = 1'b1;
            end
        end
        check("g0_accepts", acc, 3);
        for (int n = 0; n < 24; n++) begin
            step(1'b0, 1'b0, 8'h00, 8'h00);
            cyc++;
            if (busy_o[0]) begin busy_cnt++; last_busy = cyc; end
            if (fd_o[0] && cyc < 32) fd_mask[cyc] = 1'b1;
        end
        check("g0_busy_cycles", busy_cnt, 24);
        check("g0_contiguous", last_busy, 24);
        check("g0_frame_done_pos", fd_mask, (32'd1 << 8) | (32'd1 << 16) | (32'd1 << 24));
        check("g0_frames_sent", fr_o[0], 16'd3);

        // All-ones pairing: both lines high on every data bit, low in the gap.
        step(1'b1, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 8'h00, 8'h00);
        both_hi = 0;
        step(1'b0, 1'b1, 8'hFF, 8'hFF);
        if (l1_o[1] && l2_o[1]) both_hi++;
        for (int n = 0; n < 9; n++) begin
            step(1'b0, 1'b0, 8'h00, 8'h00);
            if (l1_o[1] && l2_o[1]) both_hi++;
        end
        check("ff_both_high", both_hi, 8);

        // Reset after four bits of an FF/FF word aborts it uncounted.
        step(1'b1, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b1, 8'hFF, 8'hFF);
        for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 8'h00, 8'h00);
        check("abort_mid_word", dut_out(1), e(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0));
        step(1'b1, 1'b0, 8'h00, 8'h00);
        check("abort_in_reset", dut_out(1), e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        step(1'b0, 1'b0, 8'h00, 8'h00);
        check("abort_release", dut_out(1), e(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0));

        // Counter wrap: preload 0xFFFF, one frame brings it to 0x0000.
        step(1'b0, 1'b0, 8'h00, 8'h00);
        force u_g0.frames_sent_r = 16'hFFFF;
        force u_g1.frames_sent_r = 16'hFFFF;
        mcnt[0] = 16'hFFFF;
        mcnt[1] = 16'hFFFF;
        step(1'b0, 1'b0, 8'h00, 8'h00);
        release u_g0.frames_sent_r;
        release u_g1.frames_sent_r;
        step(1'b0, 1'b1, 8'h5A, 8'hC3);
        for (int n = 0; n < 10; n++) step(1'b0, 1'b0, 8'h00, 8'h00);
        check("wrap_g0", fr_o[0], 16'h0000);
        check("wrap_g1", fr_o[1], 16'h0000);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 99) < 65),
                 8'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/b01_line_feeder.md
B01_LINE_FEEDER -- requirements
Module: b01_line_feeder

Interface
REQ-001 Parameter: WIDTH, 8, bits per serialized word (2..16).
REQ-002 Parameter: GAP, 1, idle cycles (lines driven 0) after each word (0..7).
REQ-003 Port: clock  input  1  single clock, all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  word pair offered.
REQ-006 Port: in_ready  output  1  block accepts a word pair this cycle.
REQ-007 Port: word_a  input  WIDTH  word serialized onto line1.
REQ-008 Port: word_b  input  WIDTH  word serialized onto line2.
REQ-009 Port: line1  output  1  registered serial bit A, feeds the downstream comparator FSM's line1.
REQ-010 Port: line2  output  1  registered serial bit B, feeds the downstream comparator FSM's line2.
REQ-011 Port: busy  output  1  high while in SHIFT or GAP.
REQ-012 Port: frame_done  output  1  one-cycle pulse coincident with last data bit on lines.
REQ-013 Port: frames_sent  output  16  count of completed words, wraps 0xFFFF->0x0000.

Function
REQ-014 FSM states IDLE, SHIFT, GAP; reset enters IDLE.
REQ-015 Transfer occurs on a rising edge where in_valid && in_ready; word_a/word_b are captured into two shift registers at that edge.
REQ-016 in_ready is 1 in IDLE, on the final GAP cycle, or on the final SHIFT cycle when GAP=0; otherwise 0; forced 0 while reset is high.
REQ-017 Latency: bit 0 (LSB) of a word accepted at edge k appears on line1/line2 in the cycle after edge k; bit i appears i cycles later; LSB first.
REQ-018 SHIFT lasts exactly WIDTH cycles, tracked by a bit counter of width clog2(WIDTH+1).
REQ-019 After SHIFT, GAP lasts exactly GAP cycles with line1=line2=0; GAP=0 skips the GAP state.
REQ-020 In IDLE, line1=line2=0.
REQ-021 On the final output cycle (last GAP cycle, or last bit if GAP=0): transfer accepted -> SHIFT with new word, no bubble; no transfer -> IDLE.
REQ-022 frame_done is high exactly in the cycle the MSB (bit WIDTH-1) is on the lines.
REQ-023 frames_sent increments by 1 on the edge that ends the frame_done cycle, modulo 2^16.
REQ-024 word_a/word_b changes while not transferring have no effect on lines.
REQ-025 in_valid held high with in_ready low shall not be treated as a transfer.

Reset
REQ-026 reset high at a rising edge: state=IDLE, shift registers=0, bit and gap counters=0, line1=0, line2=0, busy=0, frame_done=0, frames_sent=0.
REQ-027 Reset asserted mid-SHIFT or mid-GAP aborts the word; the aborted word is not counted.
REQ-028 First cycle after reset deassertion: in_ready=1, all other outputs 0.

Structure
REQ-029 Shared package b01_pkg holds the state enum (IDLE, SHIFT, GAP) and WIDTH/GAP default constants.
REQ-030 One sub-module, b01_dual_shreg: a pair of WIDTH-bit load/shift registers with a shared load and shift enable, outputs LSBs.
REQ-031 Top holds FSM, counters, handshake logic and output registers.

Verification
REQ-032 WIDTH=8, GAP=1, one transfer word_a=0xA5, word_b=0x0F -> line1 = 1,0,1,0,0,1,0,1 and line2 = 1,1,1,1,0,0,0,0 over 8 cycles; frame_done on the 8th; one gap cycle of 0; frames_sent=1; back to IDLE.
REQ-033 GAP=0, in_valid held high with 3 word pairs -> 24 contiguous data bits, no bubble, frame_done every 8th cycle, frames_sent=3.
REQ-034 in_valid=1 during SHIFT (not last bit) -> in_ready=0, no capture; the word is accepted only on the final output cycle.
REQ-035 reset asserted after 4 bits of word 0xFF/0xFF -> next cycle lines=0, busy=0, frames_sent unchanged (0), in_ready=1 after release.
REQ-036 Preload frames_sent to 0xFFFF by 65535 frames (or force), send 1 frame -> frames_sent=0x0000.
REQ-037 Downstream pairing: feed b01 from this block with word_a=word_b=0xFF -> b01 takes its line1&&line2 branches every bit; scoreboard compares outp/overflw to a reference model.
